// File: rtl/r5_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// r5_sdf_stage_ctrl
// Sequencing controller for one radix-5 single-path delay-feedback FFT stage.
// It counts accepted samples through a 5*L frame and decodes, per sample,
// whether the stage fills its delay lines (branches 0..3) or fires the
// butterfly (branch 4). It also provides the branch number and the position
// within the branch, which is the twiddle address. Valid, start-of-frame and
// end-of-frame markers travel through a BUF_LAT-deep shift pipeline, so they
// leave the block aligned with the data coming out of the stage's delay buffer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   sample accepted this cycle (no backpressure)
//   in_sop     first sample of a frame, qualified by in_valid
//   fill_en    registered: the sample goes into the delay lines
//   bf_en      registered: the butterfly is active
//   phase      registered branch number 0..4 of the last accepted sample
//   idx        registered position 0..L-1 within the branch
//   out_valid  valid marker, BUF_LAT cycles after the accept
//   out_sop    frame-start marker, BUF_LAT cycles after the accept
//   out_eop    frame-end marker, BUF_LAT cycles after the accept
//   busy       a frame is in progress or markers are still in flight
//   err_sop    one-cycle pulse: in_sop arrived with the counter not at 0
// ---------------------------------------------------------------------------
module r5_sdf_stage_ctrl #(
   parameter int L       = 5,
   parameter int BUF_LAT = 9,
   localparam int IW     = $clog2(5 * L)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          in_sop,
   output logic          fill_en,
   output logic          bf_en,
   output logic [2:0]    phase,
   output logic [IW-1:0] idx,
   output logic          out_valid,
   output logic          out_sop,
   output logic          out_eop,
   output logic          busy,
   output logic          err_sop
);

   localparam logic [IW-1:0] IDX_LAST = IW'(L - 1);
   localparam logic [2:0]    BR_LAST  = 3'd4;

   // The frame counter is kept as a (branch, index) pair. This pair is
   // cnt / L and cnt mod L, so the decode never needs a divider.
   logic [2:0]    br_reg, br_next, br_eff;
   logic [IW-1:0] ix_reg, ix_next, ix_eff;
   logic          eff_zero, eff_last, cnt_nonzero;

   logic          fill_reg, bf_reg, err_reg, busy_reg;
   logic [2:0]    phase_reg;
   logic [IW-1:0] idx_reg;

   // Marker pipeline: stage 0 is bit 0, and the output taps stage BUF_LAT-1.
   logic [BUF_LAT-1:0] v_reg, s_reg, e_reg;
   logic [BUF_LAT-1:0] v_next, s_next, e_next;

   assign cnt_nonzero = (br_reg != 3'd0) || (ix_reg != '0);

   // An accepted in_sop forces the effective position to 0. This restarts
   // the frame. Because eff can then never be 5L-1, a truncated frame emits
   // no end marker.
   always_comb begin
      br_eff   = br_reg;
      ix_eff   = ix_reg;
      if (in_sop) begin
         br_eff = 3'd0;
         ix_eff = '0;
      end
      eff_zero = (br_eff == 3'd0) && (ix_eff == '0);
      eff_last = (br_eff == BR_LAST) && (ix_eff == IDX_LAST);
   end

   always_comb begin
      br_next = br_reg;
      ix_next = ix_reg;
      if (in_valid) begin
         if (eff_last) begin
            br_next = 3'd0;
            ix_next = '0;
         end else if (ix_eff == IDX_LAST) begin
            br_next = br_eff + 3'd1;
            ix_next = '0;
         end else begin
            br_next = br_eff;
            ix_next = ix_eff + IW'(1);
         end
      end
   end

   // Stage 0 captures the markers of the current accept. A non-accept
   // loads a bubble.
   assign v_next[0] = in_valid;
   assign s_next[0] = in_valid & eff_zero;
   assign e_next[0] = in_valid & eff_last;

   genvar gi;
   generate
      for (gi = 1; gi < BUF_LAT; gi++) begin : g_marker_shift
         assign v_next[gi] = v_reg[gi-1];
         assign s_next[gi] = s_reg[gi-1];
         assign e_next[gi] = e_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_reg    <= 3'd0;
         ix_reg    <= '0;
         fill_reg  <= 1'b0;
         bf_reg    <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         phase_reg <= 3'd0;
         idx_reg   <= '0;
         v_reg     <= '0;
         s_reg     <= '0;
         e_reg     <= '0;
      end else begin
         br_reg   <= br_next;
         ix_reg   <= ix_next;
         fill_reg <= in_valid && (br_eff != BR_LAST);
         bf_reg   <= in_valid && (br_eff == BR_LAST);
         err_reg  <= in_valid && in_sop && cnt_nonzero;
         // busy looks at the state that will exist after this edge. It
         // therefore falls in the cycle right after the last marker leaves.
         busy_reg <= (br_next != 3'd0) || (ix_next != '0) || (|v_next);
         if (in_valid) begin
            phase_reg <= br_eff;
            idx_reg   <= ix_eff;
         end
         v_reg <= v_next;
         s_reg <= s_next;
         e_reg <= e_next;
      end
   end

   assign fill_en   = fill_reg;
   assign bf_en     = bf_reg;
   assign phase     = phase_reg;
   assign idx       = idx_reg;
   assign err_sop   = err_reg;
   assign busy      = busy_reg;
   assign out_valid = v_reg[BUF_LAT-1];
   assign out_sop   = s_reg[BUF_LAT-1];
   assign out_eop   = e_reg[BUF_LAT-1];

endmodule

// File: tb/tb_r5_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_r5_sdf_stage_ctrl
// Self-checking bench for r5_sdf_stage_ctrl with L=5 and BUF_LAT=9.
// A frame-position model tracks the integer sample count. It decodes with
// / and %, and schedules each marker into a table indexed by the absolute
// cycle in which that marker must appear. Every cycle, each scenario compares
// the DUT outputs against the model.
// ---------------------------------------------------------------------------
module tb_r5_sdf_stage_ctrl;
   localparam int L       = 5;
   localparam int BUF_LAT = 9;
   localparam int IW      = $clog2(5 * L);
   localparam int FRAME   = 5 * L;
   localparam int TSZ     = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_sop = 1'b0;
   logic          fill_en, bf_en, out_valid, out_sop, out_eop, busy, err_sop;
   logic [2:0]    phase;
   logic [IW-1:0] idx;

   r5_sdf_stage_ctrl #(.L(L), .BUF_LAT(BUF_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
      .fill_en(fill_en), .bf_en(bf_en), .phase(phase), .idx(idx),
      .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .busy(busy), .err_sop(err_sop)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   int m_cnt = 0;
   int cyc   = 0;
   bit e_fill = 0, e_bf = 0, e_err = 0;
   int e_ph = 0, e_ix = 0;
   bit sch_v [TSZ];
   bit sch_s [TSZ];
   bit sch_e [TSZ];

   function automatic logic [31:0] pack(bit f, bit b, int ph, int id, bit ov,
                                        bit os, bit oe, bit bz, bit er);
      logic [2:0] ph3;
      logic [7:0] id8;
      ph3 = ph[2:0];
      id8 = id[7:0];
      return {14'd0, f, b, ph3, id8, ov, os, oe, bz, er};
   endfunction

   function automatic logic [31:0] obs_word();
      return pack(fill_en, bf_en, int'(phase), int'(idx), out_valid, out_sop,
                  out_eop, busy, err_sop);
   endfunction

   function automatic logic [31:0] exp_word();
      bit pend;
      pend = (m_cnt != 0);
      for (int t = cyc; t < cyc + BUF_LAT; t++) pend |= sch_v[t];
      return pack(e_fill, e_bf, e_ph, e_ix, sch_v[cyc], sch_s[cyc],
                  sch_e[cyc], pend, e_err);
   endfunction

   // Drives one cycle of inputs, clocks the DUT, and advances the model to
   // the cycle in which the resulting outputs are visible.
   task automatic drive(input bit v, input bit sop, input bit rn);
      int eff;
      in_valid = v;
      in_sop   = sop;
      rst_n    = rn;
      @(posedge clk);
      #1;
      if (!rn) begin
         m_cnt = 0;
         e_fill = 0; e_bf = 0; e_err = 0; e_ph = 0; e_ix = 0;
         for (int t = cyc; t <= cyc + BUF_LAT + 1; t++) begin
            sch_v[t] = 0; sch_s[t] = 0; sch_e[t] = 0;
         end
      end else if (v) begin
         eff    = sop ? 0 : m_cnt;
         e_err  = sop && (m_cnt != 0);
         e_ph   = eff / L;
         e_ix   = eff % L;
         e_fill = (e_ph < 4);
         e_bf   = (e_ph == 4);
         m_cnt  = (eff == FRAME - 1) ? 0 : eff + 1;
         sch_v[cyc + BUF_LAT] = 1;
         sch_s[cyc + BUF_LAT] = (eff == 0);
         sch_e[cyc + BUF_LAT] = (eff == FRAME - 1);
      end else begin
         e_fill = 0; e_bf = 0; e_err = 0;
      end
      cyc++;
   endtask

   task automatic test_reset();
      logic [31:0] o, e;
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
         o = obs_word();
         e = exp_word();
         n_checks++;
         if (o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_zero cyc=%0d got=%h want=%h", cyc, o, 32'd0);
         end
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
   endtask

   // One contiguous frame with in_sop on the first sample, then a drain.
   task automatic test_single_frame();
      logic [31:0] o, e;
      int eops = 0;
      for (int i = 0; i < FRAME + BUF_LAT + 3; i++) begin
         drive(i < FRAME, i == 0, 1);
         o = obs_word();
         e = exp_word();
         eops += int'(out_eop);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL single_frame cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
      n_checks++;
      if (eops !== 1) begin
         n_fail++;
         $display("FAIL single_frame_eops got=%0d want=1", eops);
      end
   endtask

   // The same frame with a gap after every sample.
   task automatic test_gapped_frame();
      logic [31:0] o, e;
      for (int i = 0; i < 2 * FRAME + BUF_LAT + 3; i++) begin
         drive((i % 2 == 0) && (i < 2 * FRAME), i == 0, 1);
         o = obs_word();
         e = exp_word();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL gapped_frame cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
   endtask

   // Two frames without a bubble. The second frame starts by wrap-around.
   task automatic test_back_to_back();
      logic [31:0] o, e;
      int eops = 0, sops = 0, errs = 0;
      for (int i = 0; i < 2 * FRAME + BUF_LAT + 3; i++) begin
         drive(i < 2 * FRAME, i == 0, 1);
         o = obs_word();
         e = exp_word();
         eops += int'(out_eop);
         sops += int'(out_sop);
         errs += int'(err_sop);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
      n_checks++;
      if ({eops, sops, errs} !== {32'd2, 32'd2, 32'd0}) begin
         n_fail++;
         $display("FAIL back_to_back_counts got=eop%0d/sop%0d/err%0d want=2/2/0",
                  eops, sops, errs);
      end
   endtask

   // in_sop arrives on the 13th sample: the frame is truncated and restarts.
   task automatic test_resync();
      logic [31:0] o, e;
      int errs = 0;
      for (int i = 0; i < 12 + FRAME + BUF_LAT + 3; i++) begin
         drive(i < 12 + FRAME, (i == 0) || (i == 12), 1);
         o = obs_word();
         e = exp_word();
         errs += int'(err_sop);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL resync cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
      n_checks++;
      if (errs !== 1) begin
         n_fail++;
         $display("FAIL resync_err_count got=%0d want=1", errs);
      end
   endtask

   // Reset pulse at sample 17 while markers are in flight.
   task automatic test_reset_midframe();
      logic [31:0] o, e;
      for (int i = 0; i < 16 + 1 + FRAME + BUF_LAT + 3; i++) begin
         drive(i < 16 + 1 + FRAME, i == 0, i != 16);
         o = obs_word();
         e = exp_word();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_midframe cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
   endtask

   // After a frame, hold in_valid low: busy must fall right after the last
   // out_valid.
   task automatic test_drain_busy();
      logic [31:0] o, e;
      int last_ov = -1, busy_drop = -1;
      bit prev_busy = 0;
      for (int i = 0; i < FRAME + BUF_LAT + 6; i++) begin
         drive(i < FRAME, i == 0, 1);
         o = obs_word();
         e = exp_word();
         if (out_valid === 1'b1) last_ov = cyc;
         if (prev_busy && busy === 1'b0 && busy_drop < 0) busy_drop = cyc;
         prev_busy = (busy === 1'b1);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL drain_busy cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
      n_checks++;
      if (busy_drop !== last_ov + 1) begin
         n_fail++;
         $display("FAIL drain_busy_drop got=%0d want=%0d", busy_drop, last_ov + 1);
      end
   endtask

   // Random valid gaps, occasional resync and rare resets.
   task automatic test_random();
      logic [31:0] o, e;
      bit v, s, rn;
      for (int i = 0; i < 800; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         s  = ($urandom_range(0, 40) == 0);
         rn = ($urandom_range(0, 250) != 0);
         drive(v, s, rn);
         o = obs_word();
         e = exp_word();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
      for (int i = 0; i < FRAME + BUF_LAT + 3; i++) begin
         drive(0, 0, 1);
         o = obs_word();
         e = exp_word();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_gapped_frame();
      test_back_to_back();
      test_resync();
      test_reset_midframe();
      test_drain_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/r5_sdf_stage_ctrl.md
Name: r5_sdf_stage_ctrl

Overview:
Sequencing controller for one radix-5 single-path delay-feedback (SDF) FFT stage. It counts accepted complex samples through a 5*L frame and decodes, per sample, whether the stage fills its delay lines or fires the butterfly. It also gives the twiddle/branch index, and carries valid, start-of-frame and end-of-frame markers through a shift pipeline. That pipeline matches the fixed latency of the stage's 32-bit re/img delay buffers, so the markers leave aligned with the buffered data.

Parameters:
L, 5, samples per branch (stage span); frame length is 5*L; L >= 2.
BUF_LAT, 9, latency in clk cycles of the data delay buffer that the markers must track; BUF_LAT >= 1.
IW, $clog2(5*L), counter width (derived; not overridden).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  sample accepted this cycle (no backpressure)
in_sop  in  1  first sample of a frame; qualified by in_valid
fill_en  out  1  registered; sample routed into delay lines (phases 0..3)
bf_en  out  1  registered; butterfly active (phase 4)
phase  out  3  registered; branch number 0..4 of the last accepted sample
idx  out  IW  registered; position 0..L-1 within the branch (twiddle address)
out_valid  out  1  valid marker delayed BUF_LAT cycles
out_sop  out  1  frame-start marker delayed BUF_LAT cycles
out_eop  out  1  frame-end marker delayed BUF_LAT cycles
busy  out  1  frame in progress or markers still in flight
err_sop  out  1  one-cycle pulse: in_sop arrived with counter not at 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset: cnt=0; fill_en, bf_en, phase, idx, out_valid, out_sop, out_eop, busy and err_sop all 0; marker pipeline cleared. Reset in mid-frame discards the frame, with no partial markers emitted afterwards.
- Accept rule: a sample is accepted when in_valid=1. in_sop with in_valid=0 is ignored.
- Effective count: eff = 0 if in_sop, else cnt.
  - Decode phase_d = eff / L and idx_d = eff mod L.
  - Next cnt = 0 if eff = 5L-1, else eff+1.
- Control outputs: 1-cycle latency.
  - The cycle after an accept: fill_en = (phase_d < 4), bf_en = (phase_d == 4), phase = phase_d, idx = idx_d.
  - The cycle after a non-accept: fill_en = bf_en = 0; phase and idx hold; cnt holds. Gaps in in_valid are allowed anywhere.
- Resync: in_sop accepted while cnt != 0:
  - err_sop pulses for 1 cycle, aligned with fill_en.
  - The frame restarts at eff = 0.
  - No out_eop is generated for the truncated frame.
  - in_sop while cnt = 0 raises no error; the first sample after reset needs no in_sop.
- Marker pipeline: depth BUF_LAT, per stage {v, s, e}.
  - Stage 0 loads {1, eff==0, eff==5L-1} on accept, else {0,0,0}.
  - out_valid/out_sop/out_eop equal stage BUF_LAT-1, i.e. asserted exactly BUF_LAT cycles after the accept cycle.
  - Independent of in_valid gaps; a pure delay line.
- Wrap-around: after eff = 5L-1, the next accepted sample has eff = 0 and gets out_sop even without in_sop. Continuous frames need no bubble.
- busy: registered; busy = (next cnt != 0) OR (any pipeline stage v=1). It drops once the last frame has fully drained.
- Simultaneous events: an in_sop accept at eff = 5L-1 is impossible (eff is forced to 0). out_sop and out_eop are never both high for L >= 2.
- Arithmetic:
  - Divide and modulo are done with a branch counter (0..4) and an index counter (0..L-1) that track cnt; no divider.
  - phase is zero-extended to 3 bits.

Test Plan:
1. Reset then 25 contiguous in_valid with in_sop on the first (L=5, BUF_LAT=9):
   - fill_en high for accepts 0..19, bf_en high for accepts 20..24; phase steps 0,0,0,0,0,1,...,4; idx 0..4 repeating.
   - out_valid high cycles 9..33 after the first accept; out_sop at cycle 9; out_eop at cycle 33.
2. Same frame with in_valid low every other cycle:
   - Identical phase/idx sequence; cnt holds during gaps; fill_en/bf_en low in the cycle after each gap.
   - Each out_valid is exactly 9 cycles after its accept.
3. 50 contiguous samples, in_sop only on the first:
   - Second frame wraps; out_sop at sample 25 with no in_sop.
   - out_eop after samples 24 and 49; err_sop never asserts.
4. in_sop on the 13th sample of a frame:
   - err_sop pulse; phase/idx restart at 0/0; no out_eop for the truncated frame.
   - Next out_sop is 9 cycles after that accept.
5. rst_n low for 1 cycle at sample 17, while markers are in flight:
   - All outputs 0 the next cycle; no stray out_valid afterwards.
   - The next accepted sample decodes phase 0, idx 0.
6. After the final frame ends, in_valid held at 0:
   - busy stays 1 until the cycle after the last out_valid, then 0.
